// File: rtl/radix_pkg.sv
// Shared types and helpers for the mixed-radix counter.
// Holds the digit width default, the digit type, radix decode and legality.
package radix_pkg;

  localparam int DW_DEFAULT = 3;
  localparam int MAXW = 8;

  typedef logic [DW_DEFAULT-1:0] digit_t;

  // A radix field of 0 stands for the full 2^dw range.
  function automatic logic [MAXW:0] radix_decode(
    input logic [MAXW-1:0] r,
    input int unsigned     dw
  );
    logic [MAXW:0] v;
    v = {1'b0, r};
    if (r == '0)
      v = (MAXW+1)'(1) << dw;
    return v;
  endfunction

  // Radix 1 has no room to count, and an increment that reaches the
  // radix would need more than the single subtraction the adder does.
  function automatic logic is_illegal(
    input logic [MAXW-1:0] r,
    input logic [MAXW-1:0] inc,
    input int unsigned     dw
  );
    return (r == MAXW'(1)) ||
           ({1'b0, inc} >= radix_decode(r, dw));
  endfunction

endpackage

// File: rtl/mod_digit.sv
// Combinational modulo digit: nxt = (q + inc + c_in) mod r.
// Ports: q, inc, r, c_in in; nxt, c_out, illegal out.
module mod_digit
  import radix_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic [DW-1:0] q,
  input  logic [DW-1:0] inc,
  input  logic [DW-1:0] r,
  input  logic          c_in,
  output logic [DW-1:0] nxt,
  output logic          c_out,
  output logic          illegal
);

  logic [DW:0] rr;
  logic [DW:0] s;

  assign rr = (DW+1)'(radix_decode(MAXW'(r), DW));

  assign s = {1'b0, q} + {1'b0, inc} +
             {{DW{1'b0}}, c_in};

  assign c_out = (s >= rr);

  assign nxt = c_out ? DW'(s - rr) : DW'(s);

  assign illegal = is_illegal(MAXW'(r), MAXW'(inc), DW);

endmodule

// File: rtl/mixed_radix_counter.sv
// Multi-digit mixed-radix counter/accumulator with wrap or saturate.
// Ports: clk, rst_n, en, clr, load, load_val, radix, inc, ci, sat_mode; q, co, sat, cfg_err.
module mixed_radix_counter
  import radix_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int DW     = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  input  logic [DIGITS*DW-1:0] radix,
  input  logic [DIGITS*DW-1:0] inc,
  input  logic                 ci,
  input  logic                 sat_mode,
  output logic [DIGITS*DW-1:0] q,
  output logic                 co,
  output logic                 sat,
  output logic                 cfg_err
);

  logic [DIGITS:0]      c;
  logic [DIGITS-1:0]    ill;
  logic [DIGITS*DW-1:0] nxt_q;
  logic [DIGITS*DW-1:0] ld_q;
  logic [DIGITS*DW-1:0] max_q;
  logic                 any_ill;

  assign c[0]    = ci;
  assign any_ill = |ill;

  for (genvar d = 0; d < DIGITS; d++) begin : g_dig
    logic [DW:0] rr;

    assign rr = (DW+1)'(radix_decode(
                  MAXW'(radix[d*DW +: DW]), DW));

    mod_digit #(.DW(DW)) u_dig (
      .q       (q[d*DW +: DW]),
      .inc     (inc[d*DW +: DW]),
      .r       (radix[d*DW +: DW]),
      .c_in    (c[d]),
      .nxt     (nxt_q[d*DW +: DW]),
      .c_out   (c[d+1]),
      .illegal (ill[d])
    );

    assign ld_q[d*DW +: DW] =
      ({1'b0, load_val[d*DW +: DW]} < rr) ?
      load_val[d*DW +: DW] : '0;

    assign max_q[d*DW +: DW] =
      DW'(rr - (DW+1)'(1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q       <= '0;
      co      <= 1'b0;
      sat     <= 1'b0;
      cfg_err <= 1'b0;
    end else if (clr) begin
      q       <= '0;
      co      <= 1'b0;
      sat     <= 1'b0;
      cfg_err <= 1'b0;
    end else if (load) begin
      q       <= ld_q;
      co      <= 1'b0;
      cfg_err <= 1'b0;
    end else if (en) begin
      if (any_ill) begin
        co      <= 1'b0;
        cfg_err <= 1'b1;
      end else begin
        cfg_err <= 1'b0;
        if (sat_mode && c[DIGITS]) begin
          q   <= max_q;
          co  <= 1'b1;
          sat <= 1'b1;
        end else begin
          q  <= nxt_q;
          co <= c[DIGITS];
        end
      end
    end else begin
      co <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mixed_radix_counter.sv
// Scoreboard bench for mixed_radix_counter with DIGITS=2, DW=3.
// Driver pushes expected {q,co,sat,cfg_err}; monitor pops after each edge.
module tb_mixed_radix_counter;

  localparam int DIGITS = 2;
  localparam int DW     = 3;
  localparam int W      = DIGITS * DW;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, clr, load, ci, sat_mode;
  logic [W-1:0] load_val, radix, inc;
  logic [W-1:0] q;
  logic         co, sat, cfg_err;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  errors = 0;
  int  checks = 0;

  mixed_radix_counter #(.DIGITS(DIGITS), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .radix    (radix),
    .inc      (inc),
    .ci       (ci),
    .sat_mode (sat_mode),
    .q        (q),
    .co       (co),
    .sat      (sat),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input int d1, input int d0);
    logic [2:0] a, b;
    a = 3'(d1);
    b = 3'(d0);
    return {a, b};
  endfunction

  task automatic check(input string name,
                       input logic [8:0] got,
                       input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got q=%0d_%0d co=%0b sat=%0b err=%0b, want q=%0d_%0d co=%0b sat=%0b err=%0b",
               name, got[8:6], got[5:3], got[2], got[1], got[0],
               exp[8:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // One clocked step: inputs are already set; expectation queued at the edge.
  task automatic cyc(input string name, input int d1, input int d0,
                     input logic eco, input logic esat,
                     input logic eerr);
    sb_t e;
    @(posedge clk);
    e.name = name;
    e.exp  = {pk(d1, d0), eco, esat, eerr};
    sbq.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    en = 0; clr = 0; load = 0;
  endtask

  // Monitor: compares registered outputs just after each active edge.
  initial begin
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check(e.name, {q, co, sat, cfg_err}, e.exp);
      end
    end
  end

  initial begin
    rst_n = 0;
    idle();
    ci = 0; sat_mode = 0;
    load_val = '0; inc = '0;
    radix = pk(3, 5);
    #2;
    check("reset", {q, co, sat, cfg_err}, 9'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // Count d0 mod 5, d1 mod 3; wraps to zero on step 15.
    en = 1; ci = 1;
    for (int i = 1; i <= 15; i++) begin
      cyc($sformatf("count%0d", i),
          (i % 15) / 5, (i % 15) % 5, (i == 15), 0, 0);
    end

    // Multi-digit add with ripple and carry out.
    idle(); load = 1; load_val = pk(2, 4);
    cyc("load24", 2, 4, 0, 0, 0);
    idle(); en = 1; inc = pk(1, 3); ci = 0;
    cyc("add", 1, 2, 1, 0, 0);

    // Saturate, back-to-back overflow, sticky flag.
    idle(); load = 1; load_val = pk(2, 4);
    cyc("load24b", 2, 4, 0, 0, 0);
    idle(); en = 1; inc = '0; ci = 1; sat_mode = 1;
    cyc("sat1", 2, 4, 1, 1, 0);
    cyc("sat2", 2, 4, 1, 1, 0);
    idle(); sat_mode = 0;
    cyc("hold", 2, 4, 0, 1, 0);
    en = 1;
    cyc("wrap_sticky", 0, 0, 1, 1, 0);
    cyc("step_sticky", 0, 1, 0, 1, 0);

    // Illegal configurations hold q and flag cfg_err.
    inc = pk(0, 5); ci = 0;
    cyc("ill_inc", 0, 1, 0, 1, 1);
    inc = '0; ci = 1;
    cyc("legal_after", 0, 2, 0, 1, 0);
    radix = pk(1, 5);
    cyc("ill_r1", 0, 2, 0, 1, 1);
    radix = pk(3, 5);

    // Priority: clr over load over en.
    idle(); clr = 1; load = 1; en = 1; load_val = pk(2, 2);
    cyc("clr_all", 0, 0, 0, 0, 0);
    idle(); en = 1; inc = pk(0, 5); ci = 0;
    cyc("ill_pre", 0, 0, 0, 0, 1);
    load = 1; load_val = pk(1, 6);
    cyc("load_en", 1, 0, 0, 0, 0);

    // Radix encoding 0 means 8.
    idle(); inc = '0; radix = pk(3, 0);
    load = 1; load_val = pk(0, 7);
    cyc("load_r0", 0, 7, 0, 0, 0);
    idle(); en = 1; ci = 1;
    cyc("r0_wrap", 1, 0, 0, 0, 0);

    // Asynchronous reset mid-cycle with flags set.
    radix = pk(3, 5);
    idle(); load = 1; load_val = pk(2, 4);
    cyc("load24c", 2, 4, 0, 0, 0);
    idle(); en = 1; ci = 1; sat_mode = 1;
    cyc("sat_pre_rst", 2, 4, 1, 1, 0);
    #2;
    rst_n = 0;
    #1;
    check("async_rst", {q, co, sat, cfg_err}, 9'd0);
    @(posedge clk);
    #1;
    check("rst_hold", {q, co, sat, cfg_err}, 9'd0);
    @(negedge clk);
    rst_n = 1; sat_mode = 0;
    cyc("first_after_rst", 0, 1, 0, 0, 0);
    idle();

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
